// File: rtl/uart_pkg.sv
// uart_pkg: shared encodings, FSM state type and timing helpers for the UART TX path.
package uart_pkg;

   // Parity mode encodings for the PARITY parameter.
   localparam int unsigned PAR_NONE = 0;
   localparam int unsigned PAR_ODD  = 1;
   localparam int unsigned PAR_EVEN = 2;

   // Transmitter frame states.
   typedef enum logic [2:0] {
      StIdle,
      StStart,
      StData,
      StPar,
      StStop
   } txState_t;

   // Clock cycles per bit period (integer truncation).
   function automatic int unsigned calcBitCycles(input int unsigned clkHz,
                                                 input int unsigned baud);
      return clkHz / baud;
   endfunction

   // Width of a counter that runs 0 .. cycles-1.
   function automatic int unsigned calcTimerWidth(input int unsigned cycles);
      return (cycles <= 2) ? 1 : $clog2(cycles);
   endfunction

endpackage

// File: rtl/uart_tx_fifo.sv
// uart_tx_fifo: single-clock synchronous FIFO holding words waiting to be framed.
// A write while full is refused even if a read happens on the same edge.
module uart_tx_fifo #(
   parameter int unsigned WIDTH = 8,
   parameter int unsigned DEPTH = 16
) (
   input  logic                       CLK,
   input  logic                       RST_N,
   input  logic                       push,
   input  logic [WIDTH-1:0]           pushData,
   input  logic                       pop,
   output logic [WIDTH-1:0]           popData,
   output logic                       full,
   output logic                       empty,
   output logic [$clog2(DEPTH+1)-1:0] count
);

   localparam int unsigned PtrW = $clog2(DEPTH);
   localparam int unsigned CntW = $clog2(DEPTH + 1);
   localparam logic [CntW-1:0] FullCount = CntW'(DEPTH);

   logic [WIDTH-1:0] mem [DEPTH];
   logic [PtrW-1:0]  wrPtrQ;
   logic [PtrW-1:0]  rdPtrQ;
   logic [CntW-1:0]  countQ;
   logic             doPush;
   logic             doPop;

   assign full    = (countQ == FullCount);
   assign empty   = (countQ == '0);
   assign count   = countQ;
   assign popData = mem[rdPtrQ];
   assign doPush  = push && !full;
   assign doPop   = pop && !empty;

   // Pointer and occupancy bookkeeping; reset flushes the queue.
   always_ff @(posedge CLK or negedge RST_N) begin
      if (!RST_N) begin
         wrPtrQ <= '0;
         rdPtrQ <= '0;
         countQ <= '0;
      end else begin
         if (doPush) begin
            wrPtrQ <= wrPtrQ + PtrW'(1);
         end
         if (doPop) begin
            rdPtrQ <= rdPtrQ + PtrW'(1);
         end
         if (doPush && !doPop) begin
            countQ <= countQ + CntW'(1);
         end else if (doPop && !doPush) begin
            countQ <= countQ - CntW'(1);
         end
      end
   end

   // Storage array; entries are only read after being written, so no reset.
   always_ff @(posedge CLK) begin
      if (doPush) begin
         mem[wrPtrQ] <= pushData;
      end
   end

endmodule

// File: rtl/uart_tx_fifo_ctrl.sv
// uart_tx_fifo_ctrl: UART transmitter with a built-in TX FIFO. Frames are
// start / DATA_BITS LSB-first / optional parity / STOP_BITS stop, each bit
// held for CLK_HZ/BAUD cycles. Frames run back-to-back while words are queued.
module uart_tx_fifo_ctrl
   import uart_pkg::*;
#(
   parameter int unsigned CLK_HZ     = 100_000_000,
   parameter int unsigned BAUD       = 9600,
   parameter int unsigned DATA_BITS  = 8,
   parameter int unsigned PARITY     = 0,
   parameter int unsigned STOP_BITS  = 1,
   parameter int unsigned FIFO_DEPTH = 16
) (
   input  logic                            CLK,
   input  logic                            RST_N,
   input  logic                            SEND,
   input  logic [DATA_BITS-1:0]            DATA,
   output logic                            READY,
   output logic                            BUSY,
   output logic [$clog2(FIFO_DEPTH+1)-1:0] FIFO_COUNT,
   output logic                            DROP,
   output logic                            UART_TX
);

   localparam int unsigned BitCycles = calcBitCycles(CLK_HZ, BAUD);
   localparam int unsigned TimerW    = calcTimerWidth(BitCycles);
   localparam int unsigned IdxW      = $clog2(DATA_BITS);
   localparam int unsigned CntW      = $clog2(FIFO_DEPTH + 1);

   localparam logic [TimerW-1:0] LastTick = TimerW'(BitCycles - 1);
   localparam logic [IdxW-1:0]   LastData = IdxW'(DATA_BITS - 1);
   localparam logic [IdxW-1:0]   LastStop = IdxW'(STOP_BITS - 1);

   txState_t             stateQ, stateD;
   logic [TimerW-1:0]    timerQ, timerD;
   logic [IdxW-1:0]      bitIdxQ, bitIdxD;
   logic [DATA_BITS-1:0] shiftQ, shiftD;
   logic                 parBitQ, parBitD;
   logic                 txQ, txD;
   logic                 dropQ;

   logic                 bitEnd;
   logic                 loadFrame;
   logic                 fifoPop;
   logic [DATA_BITS-1:0] fifoData;
   logic                 fifoFull;
   logic                 fifoEmpty;
   logic [CntW-1:0]      fifoCount;
   logic                 newParity;

   uart_tx_fifo #(
      .WIDTH (DATA_BITS),
      .DEPTH (FIFO_DEPTH)
   ) uFifo (
      .CLK      (CLK),
      .RST_N    (RST_N),
      .push     (SEND),
      .pushData (DATA),
      .pop      (fifoPop),
      .popData  (fifoData),
      .full     (fifoFull),
      .empty    (fifoEmpty),
      .count    (fifoCount)
   );

   assign bitEnd     = (timerQ == LastTick);
   assign newParity  = (PARITY == PAR_EVEN) ? (^fifoData) : ~(^fifoData);

   assign READY      = !fifoFull;
   assign BUSY       = (stateQ != StIdle);
   assign FIFO_COUNT = fifoCount;
   assign DROP       = dropQ;
   assign UART_TX    = txQ;

   // State, timer, shifter and line registers; reset forces the line idle-high.
   always_ff @(posedge CLK or negedge RST_N) begin
      if (!RST_N) begin
         stateQ  <= StIdle;
         timerQ  <= '0;
         bitIdxQ <= '0;
         shiftQ  <= '0;
         parBitQ <= 1'b0;
         txQ     <= 1'b1;
         dropQ   <= 1'b0;
      end else begin
         stateQ  <= stateD;
         timerQ  <= timerD;
         bitIdxQ <= bitIdxD;
         shiftQ  <= shiftD;
         parBitQ <= parBitD;
         txQ     <= txD;
         dropQ   <= SEND && fifoFull;
      end
   end

   // Next-state logic; txD is the value the line takes after this edge.
   always_comb begin
      stateD    = stateQ;
      timerD    = timerQ;
      bitIdxD   = bitIdxQ;
      shiftD    = shiftQ;
      parBitD   = parBitQ;
      txD       = txQ;
      loadFrame = 1'b0;
      fifoPop   = 1'b0;

      if (stateQ != StIdle) begin
         timerD = bitEnd ? '0 : timerQ + TimerW'(1);
      end

      unique case (stateQ)
         StIdle: begin
            timerD = '0;
            txD    = 1'b1;
            if (!fifoEmpty) begin
               loadFrame = 1'b1;
            end
         end
         StStart: begin
            if (bitEnd) begin
               stateD  = StData;
               bitIdxD = '0;
               txD     = shiftQ[0];
            end
         end
         StData: begin
            if (bitEnd) begin
               if (bitIdxQ == LastData) begin
                  bitIdxD = '0;
                  if (PARITY != PAR_NONE) begin
                     stateD = StPar;
                     txD    = parBitQ;
                  end else begin
                     stateD = StStop;
                     txD    = 1'b1;
                  end
               end else begin
                  bitIdxD = bitIdxQ + IdxW'(1);
                  shiftD  = shiftQ >> 1;
                  txD     = shiftQ[1];
               end
            end
         end
         StPar: begin
            if (bitEnd) begin
               stateD  = StStop;
               bitIdxD = '0;
               txD     = 1'b1;
            end
         end
         StStop: begin
            if (bitEnd) begin
               if (bitIdxQ == LastStop) begin
                  // Chain straight into the next frame when a word is waiting.
                  if (!fifoEmpty) begin
                     loadFrame = 1'b1;
                  end else begin
                     stateD = StIdle;
                     txD    = 1'b1;
                  end
               end else begin
                  bitIdxD = bitIdxQ + IdxW'(1);
               end
            end
         end
         default: begin
            stateD = StIdle;
            txD    = 1'b1;
         end
      endcase

      if (loadFrame) begin
         fifoPop = 1'b1;
         shiftD  = fifoData;
         parBitD = newParity;
         bitIdxD = '0;
         timerD  = '0;
         stateD  = StStart;
         txD     = 1'b0;
      end
   end

endmodule

// File: doc/uart_tx_fifo_ctrl.md
# uart_tx_fifo_ctrl

Parametrised UART transmitter with a built-in transmit FIFO. It is the next-generation serial TX path for the board-to-host link. Each instance is configurable in baud rate, data width, parity and stop bits, and accepts back-to-back bytes without waiting for each frame to finish. It sits between game logic (score/event messages) and the FPGA TX pin.

## Interface
- CLK_HZ, 100_000_000, system clock frequency in Hz.
- BAUD, 9600, line rate. BIT_CYCLES = CLK_HZ/BAUD (integer truncation); BIT_CYCLES ≥ 2 required.
- DATA_BITS, 8, payload width, legal range 5..9.
- PARITY, 0, parity mode: 0 none, 1 odd, 2 even.
- STOP_BITS, 1, legal values 1 or 2.
- FIFO_DEPTH, 16, TX FIFO entries; must be a power of 2 and ≥ 2.
- CLK  in  1  system clock; all logic on the rising edge.
- RST_N  in  1  reset, asynchronous assert, active-low.
- SEND  in  1  write strobe; the word is accepted on any edge where SEND && READY.
- DATA  in  DATA_BITS  payload, sampled on the accepting edge.
- READY  out  1  FIFO not full.
- BUSY  out  1  a frame is on the line (state ≠ IDLE).
- FIFO_COUNT  out  $clog2(FIFO_DEPTH+1)  number of words waiting; excludes the word currently being shifted.
- DROP  out  1  one-cycle pulse when SEND=1 while READY=0; the word is discarded.
- UART_TX  out  1  serial line, idle high, LSB first. Registered output.

## Operation
- FSM states:
  - IDLE: on FIFO non-empty, pop, load the shift register, go to START.
  - START: drive 0.
  - DATA: drive bits LSB first, DATA_BITS bits.
  - PAR: present only if PARITY≠0.
  - STOP: drive 1, STOP_BITS bit periods.
- Each state holds the line for exactly BIT_CYCLES cycles per bit. The bit timer clears on each bit boundary and in IDLE.
- End of the last stop bit:
  - If the FIFO is non-empty, pop and go directly to START. No extra idle cycle.
  - Otherwise go to IDLE.
- Parity bit:
  - Even: XOR of the data bits.
  - Odd: inverted XOR of the data bits.
- Frame length is (1 + DATA_BITS + (PARITY≠0) + STOP_BITS) × BIT_CYCLES cycles.
- Full FIFO: the write is refused even if a pop happens on the same edge. READY is purely a function of the registered count.
- Pop and push on the same edge are allowed when not full; FIFO_COUNT stays unchanged in that case.
- Reset values:
  - UART_TX=1, READY=1, BUSY=0, DROP=0, FIFO_COUNT=0.
  - FSM in IDLE, FIFO pointers cleared.
- Reset mid-frame: UART_TX returns high asynchronously and the FIFO is flushed. No partial frame resumes after release.

## Timing
- Accepting edge E0: word written and FIFO_COUNT increments (visible after E0).
- If idle and the FIFO was empty:
  - E1: pop, FIFO_COUNT back to 0.
  - UART_TX goes low and BUSY goes high, both visible after E1.
- Start-bit low lasts cycles E1..E1+BIT_CYCLES-1. Subsequent bits follow on BIT_CYCLES boundaries.
- BUSY deasserts on the edge that ends the last stop bit, if the FIFO is empty there.
- DROP asserts on the edge after the refused SEND, for one cycle.
- Throughput: one frame per frame length, sustained while the FIFO is non-empty.

## Structure
- Package uart_pkg:
  - Parity encodings PAR_NONE/PAR_ODD/PAR_EVEN.
  - FSM state enum.
  - Function computing BIT_CYCLES and the timer width.
- Sub-module uart_tx_fifo:
  - Synchronous single-clock FIFO, parametrised width/depth.
  - Ports: push/pop/full/empty/count.
  - Same CLK/RST_N.
- Top-level holds the FSM, bit timer, bit index and shift register.

## Test plan
All scenarios use CLK_HZ=1_000_000, BAUD=100_000 (BIT_CYCLES=10).
- 8N1, SEND 0x55 once from idle:
  - UART_TX low at E1 for 10 cycles, then 1,0,1,0,1,0,1,0, then stop high.
  - BUSY high for exactly 100 cycles. FIFO_COUNT peaks at 1 after E0 and is 0 after E1.
- PARITY=2, SEND 0x07 → parity bit 1. PARITY=1, SEND 0x07 → parity bit 0. Both frames are 110 cycles.
- DATA_BITS=7, STOP_BITS=2, SEND 0x41 → 7 data bits then 20 cycles high. Frame is 100 cycles.
- Depth 16, 18 consecutive SEND cycles from idle, data 0x00..0x11:
  - 0x00..0x10 accepted; 0x11 refused, with DROP high one cycle and READY low.
  - 17 frames transmitted back-to-back in 1700 cycles with no idle gap, in order.
- Reset mid-frame: RST_N low at cycle 45 of a 0x00 frame with 3 words queued:
  - UART_TX goes high before the next edge; FIFO_COUNT, BUSY and DROP go to 0.
  - After release, the line stays idle with no frame for 200 cycles.
